alu_arbiter: RTL

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//   Arbitrates two requesters onto one shared combinational ALU. One operation
//   at a time: IDLE (grant) -> ISSUE (drive ALU, capture result) -> RESP (hold
//   result until the winner takes it).
//
//   Build option:
//     ALU_ARBITER_FIXED_PRI_EN  requester 0 always wins a tie (no round-robin)
//
//   Ports:
//     clk, rst_n                 clock, asynchronous active-low reset
//     reqN_valid/ready           request handshake, N = 0,1
//     reqN_op, reqN_a, reqN_b    operation code and operands
//     respN_valid/ready          response handshake, N = 0,1
//     resp_data, resp_err        registered result / illegal-op flag (shared)
//     alu_op, alu_a, alu_b       drive to shared ALU (zero outside ISSUE)
//     alu_result                 combinational ALU result
//     busy                       high whenever not IDLE
//
//   state | meaning
//   IDLE  | waiting for a request; grant issued combinationally
//   ISSUE | registered op driven to ALU, result captured at the edge
//   RESP  | result presented to the winner until respN_ready
// -----------------------------------------------------------------------------
module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [3:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [3:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             resp0_valid,
    input  logic             resp0_ready,
    output logic             resp1_valid,
    input  logic             resp1_ready,
    output logic [WIDTH-1:0] resp_data,
    output logic             resp_err,
    output logic [3:0]       alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t           state_q, state_d;
    logic             ptr_q, ptr_d;      // last granted requester
    logic             id_q, id_d;        // requester owning the in-flight op
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] resp_data_q, resp_data_d;
    logic             resp_err_q, resp_err_d;
    logic             winner;
    logic             op_legal;

    // Requester that would be granted if we are in IDLE.
    always_comb begin
        winner = ~req0_valid;
`ifdef ALU_ARBITER_FIXED_PRI_EN
        winner = ~req0_valid;
`else
        if (req0_valid && req1_valid) begin
            winner = ~ptr_q;
        end
`endif
    end

    // 0110 and every 1xxx code are illegal.
    assign op_legal = ~(op_q[3] | (op_q == 4'b0110));

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        id_d        = id_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        resp_data_d = resp_data_q;
        resp_err_d  = resp_err_q;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        resp0_valid = 1'b0;
        resp1_valid = 1'b0;
        alu_op      = 4'b0000;
        alu_a       = '0;
        alu_b       = '0;

        case (state_q)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    req0_ready = ~winner;
                    req1_ready = winner;
                    op_d       = winner ? req1_op : req0_op;
                    a_d        = winner ? req1_a  : req0_a;
                    b_d        = winner ? req1_b  : req0_b;
                    id_d       = winner;
                    ptr_d      = winner;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                // Illegal ops never reach the ALU; the response is forced to 0.
                if (op_legal) begin
                    alu_op      = op_q;
                    alu_a       = a_q;
                    alu_b       = b_q;
                    resp_data_d = alu_result;
                end else begin
                    resp_data_d = '0;
                end
                resp_err_d = ~op_legal;
                state_d    = RESP;
            end
            RESP: begin
                resp0_valid = ~id_q;
                resp1_valid = id_q;
                if (id_q ? resp1_ready : resp0_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= 1'b1;
            id_q        <= 1'b0;
            op_q        <= 4'b0000;
            a_q         <= '0;
            b_q         <= '0;
            resp_data_q <= '0;
            resp_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            resp_data_q <= resp_data_d;
            resp_err_q  <= resp_err_d;
        end
    end

    assign resp_data = resp_data_q;
    assign resp_err  = resp_err_q;
    assign busy      = (state_q != IDLE);

endmodule
